// File: rtl/counter_controller.sv
// Counter controller: decodes bus writes into a 16-bit initial count, load strobe, count enable and timer output.
// Optional macro CNT_CTRL_RATEGEN_EN adds mode 2 (rate generator with automatic reload on terminal count).
module counter_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        a0,
    input  logic [7:0]  din,
    input  logic        gate,
    input  logic        counting_complete,
    output logic        load,
    output logic        enable,
    output logic [15:0] new_count,
    output logic        out_sig
);
    typedef enum logic [2:0] {IDLE, WAIT_LSB, WAIT_MSB, LOAD, RUN, DONE} state_t;

    localparam logic [1:0] RW_LSB = 2'b01;
    localparam logic [1:0] RW_MSB = 2'b10;
    localparam logic [2:0] MODE0  = 3'b000;
    localparam logic [2:0] MODE2  = 3'b010;

    state_t      state;
    logic [1:0]  rw;
    logic [2:0]  mode;
    logic [7:0]  lsb;
    logic [7:0]  msb;
    logic        mode_ok;
    logic        ctrl_valid;
    logic        data_wr;
    logic        unused_din;

    always_comb begin
`ifdef CNT_CTRL_RATEGEN_EN
        mode_ok = (din[3:1] == MODE0) || (din[3:1] == MODE2);
`else
        mode_ok = (din[3:1] == MODE0);
`endif
    end

    // Invalid control words behave exactly as if no write happened.
    assign ctrl_valid = wr_en && a0 && (din[5:4] != 2'b00) && mode_ok;
    assign data_wr    = wr_en && !a0;
    assign unused_din = ^{din[7:6], din[0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            load      <= 1'b0;
            enable    <= 1'b0;
            new_count <= 16'h0000;
            out_sig   <= 1'b0;
            rw        <= 2'b00;
            mode      <= MODE0;
            lsb       <= 8'h00;
            msb       <= 8'h00;
        end else begin
            load <= 1'b0;
            if (ctrl_valid) begin
                rw      <= din[5:4];
                mode    <= din[3:1];
                enable  <= 1'b0;
                out_sig <= (din[3:1] == MODE2);
                state   <= (din[5:4] == RW_MSB) ? WAIT_MSB : WAIT_LSB;
            end else if (data_wr && state == WAIT_MSB) begin
                msb <= din;
                if (rw == RW_MSB)
                    lsb <= 8'h00;
                state <= LOAD;
            end else if (data_wr && state != IDLE) begin
                // First byte of a count; also restarts a running or finished count.
                enable  <= 1'b0;
                out_sig <= (mode == MODE2);
                if (rw == RW_MSB) begin
                    msb   <= din;
                    lsb   <= 8'h00;
                    state <= LOAD;
                end else begin
                    lsb <= din;
                    if (rw == RW_LSB) begin
                        msb   <= 8'h00;
                        state <= LOAD;
                    end else begin
                        state <= WAIT_MSB;
                    end
                end
            end else begin
                case (state)
                    LOAD: begin
                        load      <= 1'b1;
                        new_count <= {msb, lsb};
                        state     <= RUN;
                    end
                    RUN: begin
                        enable <= gate;
                        if (mode == MODE0) begin
                            if (counting_complete) begin
                                out_sig <= 1'b1;
                                enable  <= 1'b0;
                                state   <= DONE;
                            end
                        end
`ifdef CNT_CTRL_RATEGEN_EN
                        else if (counting_complete) begin
                            out_sig   <= 1'b0;
                            load      <= 1'b1;
                            new_count <= {msb, lsb};
                        end else begin
                            out_sig <= 1'b1;
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_counter_controller.sv
// Self-checking bench for counter_controller; mode 2 scenarios depend on CNT_CTRL_RATEGEN_EN.
module tb_counter_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        a0;
    logic [7:0]  din;
    logic        gate;
    logic        counting_complete;
    logic        load;
    logic        enable;
    logic [15:0] new_count;
    logic        out_sig;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_controller dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .a0(a0), .din(din), .gate(gate),
        .counting_complete(counting_complete), .load(load), .enable(enable),
        .new_count(new_count), .out_sig(out_sig)
    );

    // Count assembled from the bytes written, by read/write format.
    function automatic logic [15:0] ref_count(input logic [1:0] rw, input logic [7:0] b0, input logic [7:0] b1);
        case (rw)
            2'b01:   return 16'(b0);
            2'b10:   return 16'(b0) * 16'd256;
            default: return 16'(b1) * 16'd256 + 16'(b0);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_ctrl(input logic [7:0] d);
        wr_en = 1'b1; a0 = 1'b1; din = d;
        tick();
        wr_en = 1'b0; a0 = 1'b0;
    endtask

    task automatic write_data(input logic [7:0] d);
        wr_en = 1'b1; a0 = 1'b0; din = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Control word plus the data bytes it asks for, then the load pulse.
    task automatic program_count(input logic [7:0] ctrl, input logic [7:0] b0, input logic [7:0] b1,
                                 output logic [15:0] exp);
        write_ctrl(ctrl);
        write_data(b0);
        if (ctrl[5:4] == 2'b11)
            write_data(b1);
        exp = ref_count(ctrl[5:4], b0, b1);
        checks++;
        if (load !== 1'b0) begin errors++; $display("FAIL early_load got %b exp 0", load); end
        tick();
        checks++;
        if (load !== 1'b1 || new_count !== exp || enable !== 1'b0) begin
            errors++;
            $display("FAIL load_pulse got load=%b count=%h en=%b exp load=1 count=%h en=0", load, new_count, enable, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; wr_en = 1'b0; a0 = 1'b0; din = 8'h00; gate = 1'b0; counting_complete = 1'b0;
        tick();
        tick();
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_load got %b exp 0", load); end
        checks++; if (enable !== 1'b0) begin errors++; $display("FAIL reset_enable got %b exp 0", enable); end
        checks++; if (new_count !== 16'h0000) begin errors++; $display("FAIL reset_count got %h exp 0000", new_count); end
        checks++; if (out_sig !== 1'b0) begin errors++; $display("FAIL reset_out got %b exp 0", out_sig); end
        rst = 1'b1;
        write_data(8'h55);
        tick();
        tick();
        checks++;
        if (load !== 1'b0 || new_count !== 16'h0000) begin
            errors++; $display("FAIL idle_data got load=%b count=%h exp load=0 count=0000", load, new_count);
        end
    endtask

    task automatic test_mode0_basic();
        logic [15:0] exp;
        gate = 1'b1;
        write_ctrl(8'h30);
        checks++;
        if (out_sig !== 1'b0 || enable !== 1'b0) begin
            errors++; $display("FAIL m0_ctrl got out=%b en=%b exp out=0 en=0", out_sig, enable);
        end
        program_count(8'h30, 8'h03, 8'h00, exp);
        tick();
        checks++;
        if (enable !== 1'b1 || load !== 1'b0) begin
            errors++; $display("FAIL m0_run got en=%b load=%b exp en=1 load=0", enable, load);
        end
        counting_complete = 1'b1;
        tick();
        counting_complete = 1'b0;
        checks++;
        if (out_sig !== 1'b1 || enable !== 1'b0) begin
            errors++; $display("FAIL m0_complete got out=%b en=%b exp out=1 en=0", out_sig, enable);
        end
        tick();
        counting_complete = 1'b1;
        tick();
        counting_complete = 1'b0;
        tick();
        checks++;
        if (out_sig !== 1'b1 || enable !== 1'b0 || load !== 1'b0) begin
            errors++; $display("FAIL m0_done_hold got out=%b en=%b load=%b exp out=1 en=0 load=0", out_sig, enable, load);
        end
    endtask

    task automatic test_byte_modes();
        logic [15:0] exp;
        logic [1:0]  rw;
        program_count(8'h10, 8'h04, 8'h00, exp);
        program_count(8'h20, 8'h01, 8'h00, exp);
        for (int i = 0; i < 8; i++) begin
            rw = 2'($urandom_range(1, 3));
            gate = 1'($urandom_range(0, 1));
            program_count({2'b00, rw, 4'b0000}, 8'($urandom), 8'($urandom), exp);
            tick();
        end
    endtask

    task automatic test_rewrite_running();
        logic [15:0] exp;
        gate = 1'b1;
        program_count(8'h10, 8'h07, 8'h00, exp);
        tick();
        tick();
        checks++; if (enable !== 1'b1) begin errors++; $display("FAIL rw_running got en=%b exp 1", enable); end
        write_data(8'h05);
        checks++;
        if (enable !== 1'b0 || out_sig !== 1'b0 || load !== 1'b0) begin
            errors++; $display("FAIL rw_restart got en=%b out=%b load=%b exp 0 0 0", enable, out_sig, load);
        end
        tick();
        checks++;
        if (load !== 1'b1 || new_count !== ref_count(2'b01, 8'h05, 8'h00)) begin
            errors++; $display("FAIL rw_reload got load=%b count=%h exp load=1 count=0005", load, new_count);
        end
        tick();
        counting_complete = 1'b1;
        tick();
        counting_complete = 1'b0;
        checks++; if (out_sig !== 1'b1) begin errors++; $display("FAIL rw_complete got out=%b exp 1", out_sig); end
        write_data(8'h06);
        checks++;
        if (out_sig !== 1'b0 || enable !== 1'b0) begin
            errors++; $display("FAIL rw_from_done got out=%b en=%b exp 0 0", out_sig, enable);
        end
        tick();
        checks++;
        if (load !== 1'b1 || new_count !== 16'h0006) begin
            errors++; $display("FAIL rw_done_load got load=%b count=%h exp load=1 count=0006", load, new_count);
        end
    endtask

    task automatic test_gate();
        logic [15:0] exp;
        logic        g;
        gate = 1'b1;
        program_count(8'h10, 8'($urandom_range(1, 255)), 8'h00, exp);
        tick();
        for (int i = 0; i < 12; i++) begin
            g = 1'($urandom_range(0, 1));
            gate = g;
            tick();
            checks++;
            if (enable !== g) begin errors++; $display("FAIL gate_follow[%0d] got en=%b exp %b", i, enable, g); end
        end
        gate = 1'b1;
        tick();
        wr_en = 1'b1; a0 = 1'b0; din = 8'h09; counting_complete = 1'b1;
        tick();
        wr_en = 1'b0; counting_complete = 1'b0;
        checks++;
        if (out_sig !== 1'b0 || enable !== 1'b0) begin
            errors++; $display("FAIL coincident got out=%b en=%b exp out=0 en=0", out_sig, enable);
        end
        tick();
        checks++;
        if (load !== 1'b1 || new_count !== 16'h0009) begin
            errors++; $display("FAIL coincident_load got load=%b count=%h exp load=1 count=0009", load, new_count);
        end
        tick();
        checks++;
        if (enable !== 1'b1 || out_sig !== 1'b0) begin
            errors++; $display("FAIL coincident_run got en=%b out=%b exp en=1 out=0", enable, out_sig);
        end
    endtask

    task automatic test_reset_midrun();
        logic [15:0] exp;
        gate = 1'b1;
        program_count(8'h10, 8'h21, 8'h00, exp);
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (load !== 1'b0 || enable !== 1'b0 || new_count !== 16'h0000 || out_sig !== 1'b0) begin
            errors++; $display("FAIL rst_midrun got load=%b en=%b count=%h out=%b exp all 0", load, enable, new_count, out_sig);
        end
        rst = 1'b1;
        write_ctrl(8'h10);
        write_data(8'h22);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checks++;
        if (load !== 1'b0 || new_count !== 16'h0000) begin
            errors++; $display("FAIL rst_midload got load=%b count=%h exp load=0 count=0000", load, new_count);
        end
        tick();
        tick();
        checks++; if (load !== 1'b0) begin errors++; $display("FAIL rst_no_load got %b exp 0", load); end
        program_count(8'h10, 8'h11, 8'h00, exp);
        tick();
        write_ctrl(8'h00);
        checks++;
        if (enable !== 1'b1 || new_count !== 16'h0011) begin
            errors++; $display("FAIL ctrl00 got en=%b count=%h exp en=1 count=0011", enable, new_count);
        end
        write_ctrl(8'h3E);
        checks++;
        if (enable !== 1'b1 || load !== 1'b0 || out_sig !== 1'b0) begin
            errors++; $display("FAIL ctrl3E got en=%b load=%b out=%b exp en=1 load=0 out=0", enable, load, out_sig);
        end
        write_data(8'h12);
        tick();
        checks++;
        if (load !== 1'b1 || new_count !== 16'h0012) begin
            errors++; $display("FAIL after_ignored got load=%b count=%h exp load=1 count=0012", load, new_count);
        end
    endtask

    task automatic test_mode2();
        logic [15:0] exp;
        gate = 1'b1;
`ifdef CNT_CTRL_RATEGEN_EN
        program_count(8'h34, 8'h03, 8'h00, exp);
        checks++; if (out_sig !== 1'b1) begin errors++; $display("FAIL m2_out_init got %b exp 1", out_sig); end
        tick();
        checks++; if (enable !== 1'b1) begin errors++; $display("FAIL m2_enable got %b exp 1", enable); end
        for (int i = 0; i < 3; i++) begin
            tick();
            counting_complete = 1'b1;
            tick();
            counting_complete = 1'b0;
            checks++;
            if (out_sig !== 1'b0 || load !== 1'b1 || new_count !== exp) begin
                errors++; $display("FAIL m2_reload[%0d] got out=%b load=%b count=%h exp out=0 load=1 count=%h", i, out_sig, load, new_count, exp);
            end
            tick();
            checks++;
            if (out_sig !== 1'b1 || load !== 1'b0) begin
                errors++; $display("FAIL m2_recover[%0d] got out=%b load=%b exp out=1 load=0", i, out_sig, load);
            end
        end
`else
        program_count(8'h10, 8'h03, 8'h00, exp);
        tick();
        write_ctrl(8'h34);
        checks++;
        if (enable !== 1'b1 || out_sig !== 1'b0) begin
            errors++; $display("FAIL m2_ignored got en=%b out=%b exp en=1 out=0", enable, out_sig);
        end
        counting_complete = 1'b1;
        tick();
        counting_complete = 1'b0;
        checks++;
        if (out_sig !== 1'b1 || load !== 1'b0) begin
            errors++; $display("FAIL m2_no_reload got out=%b load=%b exp out=1 load=0", out_sig, load);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_mode0_basic();
        test_byte_modes();
        test_rewrite_running();
        test_gate();
        test_reset_midrun();
        test_mode2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
